router_sync_multi: RTL and testbench
====================================

ROUTER_SYNC_MULTI -- requirements
Module: router_sync_multi

Interface
REQ-001 Parameter NUM_CH, default 3: number of destination channels, SHALL be 2..16.
REQ-002 Parameter ADDR_W, default 2: address width, SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-003 Parameter TIMEOUT, default 30: idle cycles before soft reset, SHALL be 2..1023.
REQ-004 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 det_addr  input  1  header-address-valid strobe from the FSM.
REQ-008 din  input  ADDR_W  destination address.
REQ-009 wr_en_reg  input  1  FSM write request.
REQ-010 full  input  NUM_CH  per-channel FIFO full.
REQ-011 empty  input  NUM_CH  per-channel FIFO empty.
REQ-012 read_en  input  NUM_CH  per-channel destination read enable.
REQ-013 wr_en  output  NUM_CH  one-hot FIFO write enable.
REQ-014 fifo_full  output  1  full flag of the addressed channel.
REQ-015 valid_out  output  NUM_CH  per-channel data-available flag.
REQ-016 soft_rst  output  NUM_CH  per-channel soft reset pulse.
REQ-017 addr_err  output  1  latched address is >= NUM_CH.

Function
REQ-018 On a clock edge with det_addr=1, din SHALL be captured into addr_q; otherwise addr_q SHALL hold.
REQ-019 wr_en SHALL be combinational: bit addr_q set when wr_en_reg=1 and addr_err=0, else all zero.
REQ-020 Same-cycle det_addr and wr_en_reg SHALL decode wr_en from the previous addr_q (new address effective next cycle).
REQ-021 fifo_full SHALL equal full[addr_q] combinationally; when addr_err=1, fifo_full SHALL be 1.
REQ-022 addr_err SHALL be combinational (addr_q >= NUM_CH); wr_en SHALL never assert while addr_err=1.
REQ-023 valid_out[i] SHALL equal ~empty[i] combinationally, zero latency.
REQ-024 Per channel, a counter SHALL increment each cycle with valid_out[i]=1 and read_en[i]=0, and clear on any cycle where either fails.
REQ-025 When the counter equals TIMEOUT-1 and the idle condition still holds, soft_rst[i] SHALL be 1 for exactly the next cycle and the counter SHALL clear.
REQ-026 soft_rst[i] SHALL therefore first assert at the TIMEOUT-th rising edge of an unbroken idle run; an idle run longer than TIMEOUT SHALL repeat the pulse every TIMEOUT cycles.
REQ-027 read_en[i]=1 on the cycle the counter reaches TIMEOUT-1 SHALL suppress the pulse and clear the counter.
REQ-028 Channels SHALL time out independently; simultaneous pulses on several channels SHALL be permitted.
REQ-029 Counter width SHALL be $clog2(TIMEOUT); no wrap-around SHALL occur.

Reset
REQ-030 rst=0 at a rising edge SHALL clear addr_q, all counters and soft_rst, overriding det_addr and idle conditions in that cycle.
REQ-031 After reset: wr_en=0, soft_rst=0, addr_err=0, fifo_full=full[0], valid_out=~empty.
REQ-032 Reset mid-countdown SHALL restart the idle count from zero after release.

Configuration
REQ-033 Macro ROUTER_SYNC_SOFT_RST_EN defined: counters and soft_rst behave per REQ-024..029.
REQ-034 Macro undefined: counters SHALL not be instantiated and soft_rst SHALL be constant zero; all other behaviour unchanged.

Structure
REQ-035 Package router_pkg SHALL hold ROUTER_NUM_CH, ROUTER_ADDR_W, ROUTER_SOFT_RST_TIMEOUT defaults and the one-hot decode function.
REQ-036 Per-channel timeout logic SHALL be sub-module router_sync_timeout (params TIMEOUT; ports clk, rst, valid, read_en, soft_rst), generated NUM_CH times.

Verification
REQ-037 Reset, then det_addr=1 din=2, next cycle wr_en_reg=1 -> wr_en=3'b100; din=0 with det_addr -> wr_en=3'b001 from following cycle.
REQ-038 addr_q=1, full=3'b010 -> fifo_full=1; full=3'b101 -> fifo_full=0; din=3 latched -> addr_err=1, fifo_full=1, wr_en=0.
REQ-039 empty[0]=0, read_en[0]=0 held 30 cycles -> soft_rst[0]=1 for one cycle at edge 30, again at edge 60 if held.
REQ-040 Same idle run with read_en[0]=1 at cycle 29 -> no soft_rst[0]; count restarts.
REQ-041 rst=0 at cycle 20 of idle run -> soft_rst stays 0, pulse only after 30 further idle cycles.
REQ-042 Build without ROUTER_SYNC_SOFT_RST_EN, repeat REQ-039 -> soft_rst=0 throughout, REQ-037/038 unchanged.

Source files
------------

// File: rtl/router_sync_multi_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared defaults and helpers for the synchronous router block.
//
// Contents:
//   ROUTER_NUM_CH            default number of destination channels
//   ROUTER_ADDR_W            default destination address width
//   ROUTER_SOFT_RST_TIMEOUT  default idle cycles before a channel soft reset
//   ROUTER_MAX_CH            widest channel vector the helpers support
//   ROUTER_IDX_W             index width matching ROUTER_MAX_CH
//   router_ch_vec_t          full-width channel vector type
//   router_onehot()          one-hot decode of a channel index
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_NUM_CH           = 3;
    localparam int ROUTER_ADDR_W           = 2;
    localparam int ROUTER_SOFT_RST_TIMEOUT = 30;

    // Helpers work on the widest legal channel count; callers slice down.
    localparam int ROUTER_MAX_CH = 16;
    localparam int ROUTER_IDX_W  = 4;

    typedef logic [ROUTER_MAX_CH-1:0] router_ch_vec_t;

    // One-hot decode of a channel index into a full-width channel vector.
    function automatic router_ch_vec_t router_onehot(input logic [ROUTER_IDX_W-1:0] idx);
        router_ch_vec_t v;
        v      = {ROUTER_MAX_CH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/router_sync_multi_timeout.sv
// -----------------------------------------------------------------------------
// router_sync_timeout
// Per-channel idle watchdog. Counts consecutive cycles in which the channel
// holds data (valid=1) that nobody reads (read_en=0). On the TIMEOUT-th such
// cycle it raises soft_rst for exactly one cycle and starts counting again,
// so an unbroken idle run pulses every TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT   idle cycles before a pulse, 2..1023
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-low reset
//   valid     channel holds data
//   read_en   channel is being read this cycle
//   soft_rst  one-cycle soft reset pulse (registered)
// -----------------------------------------------------------------------------
module router_sync_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_SOFT_RST_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic read_en,
    output logic soft_rst
);

    // The counter only ever reaches TIMEOUT-1, so this width never wraps.
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_rst;
    logic             w_idle;

    assign w_idle = valid & ~read_en;

    // Idle counter and soft-reset pulse; any break in the idle run clears both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= CNT_ZERO;
            r_soft_rst <= 1'b0;
        end else if (w_idle) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt      <= CNT_ZERO;
                r_soft_rst <= 1'b1;
            end else begin
                r_cnt      <= r_cnt + CNT_ONE;
                r_soft_rst <= 1'b0;
            end
        end else begin
            r_cnt      <= CNT_ZERO;
            r_soft_rst <= 1'b0;
        end
    end

    assign soft_rst = r_soft_rst;

endmodule

// File: rtl/router_sync_multi.sv
// -----------------------------------------------------------------------------
// router_sync_multi
// Synchronizer between the router FSM and NUM_CH destination FIFOs.
// Latches the header address, steers FSM writes to the addressed FIFO,
// reports that FIFO's full flag, exposes per-channel data-available flags
// and, optionally, soft-resets channels whose data sits unread too long.
//
// Configuration macro:
//   ROUTER_SYNC_SOFT_RST_EN  defined   -> per-channel idle watchdogs built
//                            undefined -> no watchdogs, soft_rst tied to zero
//
// Parameters:
//   NUM_CH   destination channels, 2..16
//   ADDR_W   address width, 2**ADDR_W >= NUM_CH
//   TIMEOUT  idle cycles before soft reset, 2..1023
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   det_addr   header address valid; captures din
//   din        destination address
//   wr_en_reg  FSM write request
//   full       per-channel FIFO full
//   empty      per-channel FIFO empty
//   read_en    per-channel destination read enable
//   wr_en      one-hot FIFO write enable (combinational)
//   fifo_full  full flag of the addressed channel (1 on bad address)
//   valid_out  per-channel data available (~empty)
//   soft_rst   per-channel soft reset pulse (registered)
//   addr_err   latched address is not a real channel
// -----------------------------------------------------------------------------
module router_sync_multi
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = ROUTER_ADDR_W,
    parameter int TIMEOUT = ROUTER_SOFT_RST_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              det_addr,
    input  logic [ADDR_W-1:0] din,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_en,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] valid_out,
    output logic [NUM_CH-1:0] soft_rst,
    output logic              addr_err
);

    // One extra bit so NUM_CH=16 with ADDR_W=4 still compares correctly.
    localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0]       r_addr_q;
    logic                    w_addr_err;
    logic [ROUTER_IDX_W-1:0] w_idx;
    router_ch_vec_t          w_dec;
    router_ch_vec_t          w_full_ext;
    logic [NUM_CH-1:0]       w_wr_en;
    logic                    w_fifo_full;
    logic [NUM_CH-1:0]       w_valid;
    logic [NUM_CH-1:0]       w_soft_rst;
    logic                    w_unused_bits;

    // Header address latch; a write in the same cycle still uses the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr_q <= {ADDR_W{1'b0}};
        end else if (det_addr) begin
            r_addr_q <= din;
        end else begin
            r_addr_q <= r_addr_q;
        end
    end

    assign w_addr_err = ({1'b0, r_addr_q} >= NUM_CH_EXT);

    // Out-of-range addresses may alias after this resize; addr_err masks them.
    assign w_idx      = ROUTER_IDX_W'(r_addr_q);
    assign w_dec      = router_onehot(w_idx);
    assign w_full_ext = ROUTER_MAX_CH'(full);

    // Write steering and addressed-full selection.
    always_comb begin
        w_wr_en     = {NUM_CH{1'b0}};
        w_fifo_full = 1'b1;
        if (w_addr_err) begin
            w_wr_en     = {NUM_CH{1'b0}};
            w_fifo_full = 1'b1;
        end else begin
            w_fifo_full = w_full_ext[w_idx];
            if (wr_en_reg) begin
                w_wr_en = w_dec[NUM_CH-1:0];
            end else begin
                w_wr_en = {NUM_CH{1'b0}};
            end
        end
    end

    assign w_valid = ~empty;

`ifdef ROUTER_SYNC_SOFT_RST_EN
    // Independent watchdog per channel; several may pulse together.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_timeout
        router_sync_timeout #(
            .TIMEOUT (TIMEOUT)
        ) u_timeout (
            .clk      (clk),
            .rst      (rst),
            .valid    (w_valid[ch]),
            .read_en  (read_en[ch]),
            .soft_rst (w_soft_rst[ch])
        );
    end

    // Decode bits above NUM_CH are never steered anywhere.
    assign w_unused_bits = ^w_dec;
`else
    assign w_soft_rst = {NUM_CH{1'b0}};

    // Without watchdogs read_en has no consumer.
    assign w_unused_bits = ^{w_dec, read_en};
`endif

    assign wr_en     = w_wr_en;
    assign fifo_full = w_fifo_full;
    assign valid_out = w_valid;
    assign soft_rst  = w_soft_rst;
    assign addr_err  = w_addr_err;

endmodule

// File: tb/tb_router_sync_multi.sv
// Directed self-checking bench for router_sync_multi (default parameters).
// Soft-reset expectations follow ROUTER_SYNC_SOFT_RST_EN: pulses when it is
// defined, constant zero otherwise.
module tb_router_sync_multi;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;

`ifdef ROUTER_SYNC_SOFT_RST_EN
    localparam bit SRE = 1'b1;
`else
    localparam bit SRE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              det_addr;
    logic [ADDR_W-1:0] din;
    logic              wr_en_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_en;
    logic [NUM_CH-1:0] wr_en;
    logic              fifo_full;
    logic [NUM_CH-1:0] valid_out;
    logic [NUM_CH-1:0] soft_rst;
    logic              addr_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    router_sync_multi dut (
        .clk       (clk),
        .rst       (rst),
        .det_addr  (det_addr),
        .din       (din),
        .wr_en_reg (wr_en_reg),
        .full      (full),
        .empty     (empty),
        .read_en   (read_en),
        .wr_en     (wr_en),
        .fifo_full (fifo_full),
        .valid_out (valid_out),
        .soft_rst  (soft_rst),
        .addr_err  (addr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; det_addr = 1'b1; din = 2'd2; wr_en_reg = 1'b0;
        full = 3'b110; empty = 3'b010; read_en = 3'b000;
        step(); step();
        rst = 1'b1; det_addr = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 3'b000) $display("FAIL reset_wr_en: got %b expected %b", wr_en, 3'b000);
        else n_pass++;
        n_checks++;
        if (soft_rst !== 3'b000) $display("FAIL reset_soft_rst: got %b expected %b", soft_rst, 3'b000);
        else n_pass++;
        n_checks++;
        if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b expected %b", addr_err, 1'b0);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full: got %b expected %b", fifo_full, 1'b0);
        else n_pass++;
        n_checks++;
        if (valid_out !== 3'b101) $display("FAIL reset_valid_out: got %b expected %b", valid_out, 3'b101);
        else n_pass++;
        // reset overrode det_addr, so the address is channel 0
        wr_en_reg = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 3'b001) $display("FAIL reset_addr_cleared: got %b expected %b", wr_en, 3'b001);
        else n_pass++;
        wr_en_reg = 1'b0;
        full = 3'b000; empty = 3'b111;
    endtask

    task automatic test_decode();
        det_addr = 1'b1; din = 2'd2;
        step();
        det_addr = 1'b0; wr_en_reg = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 3'b100) $display("FAIL decode_ch2: got %b expected %b", wr_en, 3'b100);
        else n_pass++;
        det_addr = 1'b1; din = 2'd0;
        #1;
        n_checks++;
        if (wr_en !== 3'b100) $display("FAIL decode_same_cycle: got %b expected %b", wr_en, 3'b100);
        else n_pass++;
        step();
        det_addr = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 3'b001) $display("FAIL decode_ch0: got %b expected %b", wr_en, 3'b001);
        else n_pass++;
        det_addr = 1'b1; din = 2'd1;
        step();
        det_addr = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 3'b010) $display("FAIL decode_ch1: got %b expected %b", wr_en, 3'b010);
        else n_pass++;
        wr_en_reg = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 3'b000) $display("FAIL decode_no_req: got %b expected %b", wr_en, 3'b000);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        // address is 1 from the previous test
        full = 3'b010;
        #1;
        n_checks++;
        if (fifo_full !== 1'b1) $display("FAIL full_ch1_set: got %b expected %b", fifo_full, 1'b1);
        else n_pass++;
        full = 3'b101;
        #1;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL full_ch1_clear: got %b expected %b", fifo_full, 1'b0);
        else n_pass++;
        det_addr = 1'b1; din = 2'd3;
        step();
        det_addr = 1'b0; wr_en_reg = 1'b1; full = 3'b000;
        #1;
        n_checks++;
        if (addr_err !== 1'b1) $display("FAIL bad_addr_err: got %b expected %b", addr_err, 1'b1);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b1) $display("FAIL bad_addr_full: got %b expected %b", fifo_full, 1'b1);
        else n_pass++;
        n_checks++;
        if (wr_en !== 3'b000) $display("FAIL bad_addr_wr_en: got %b expected %b", wr_en, 3'b000);
        else n_pass++;
        wr_en_reg = 1'b0;
        det_addr = 1'b1; din = 2'd0; full = 3'b001;
        step();
        det_addr = 1'b0;
        #1;
        n_checks++;
        if (addr_err !== 1'b0) $display("FAIL good_addr_err: got %b expected %b", addr_err, 1'b0);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b1) $display("FAIL full_ch0_set: got %b expected %b", fifo_full, 1'b1);
        else n_pass++;
        full = 3'b000;
    endtask

    task automatic test_valid_out();
        empty = 3'b011;
        #1;
        n_checks++;
        if (valid_out !== 3'b100) $display("FAIL valid_out_a: got %b expected %b", valid_out, 3'b100);
        else n_pass++;
        empty = 3'b100;
        #1;
        n_checks++;
        if (valid_out !== 3'b011) $display("FAIL valid_out_b: got %b expected %b", valid_out, 3'b011);
        else n_pass++;
        empty = 3'b111;
        #1;
    endtask

    task automatic test_timeout();
        logic [NUM_CH-1:0] exp;
        rst = 1'b0; empty = 3'b110; read_en = 3'b000;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 65; e++) begin
            step();
            exp = {2'b00, (SRE && (e == 30 || e == 60))};
            n_checks++;
            if (soft_rst !== exp)
                $display("FAIL timeout_edge%0d: got %b expected %b", e, soft_rst, exp);
            else n_pass++;
        end
        empty = 3'b111;
    endtask

    task automatic test_read_suppress();
        logic [NUM_CH-1:0] exp;
        rst = 1'b0; empty = 3'b110; read_en = 3'b000;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            read_en = (e == 30) ? 3'b001 : 3'b000;
            step();
            exp = {2'b00, (SRE && e == 60)};
            n_checks++;
            if (soft_rst !== exp)
                $display("FAIL suppress_edge%0d: got %b expected %b", e, soft_rst, exp);
            else n_pass++;
        end
        read_en = 3'b000; empty = 3'b111;
    endtask

    task automatic test_reset_mid();
        logic [NUM_CH-1:0] exp;
        rst = 1'b0; empty = 3'b110; read_en = 3'b000;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            rst = (e == 20) ? 1'b0 : 1'b1;
            step();
            exp = {2'b00, (SRE && e == 50)};
            n_checks++;
            if (soft_rst !== exp)
                $display("FAIL rst_mid_edge%0d: got %b expected %b", e, soft_rst, exp);
            else n_pass++;
        end
        rst = 1'b1; empty = 3'b111;
    endtask

    task automatic test_multi_channel();
        logic [NUM_CH-1:0] exp;
        rst = 1'b0; empty = 3'b000; read_en = 3'b010;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            exp = (SRE && e == 30) ? 3'b101 : 3'b000;
            n_checks++;
            if (soft_rst !== exp)
                $display("FAIL multi_edge%0d: got %b expected %b", e, soft_rst, exp);
            else n_pass++;
        end
        read_en = 3'b000; empty = 3'b111;
    endtask

    initial begin
        rst = 1'b0; det_addr = 1'b0; din = 2'd0; wr_en_reg = 1'b0;
        full = 3'b000; empty = 3'b111; read_en = 3'b000;
        test_reset();
        test_decode();
        test_fifo_full();
        test_valid_out();
        test_timeout();
        test_read_suppress();
        test_reset_mid();
        test_multi_channel();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
